// File: rtl/ysyx_23060208_rd_arbiter_pkg.sv
// Shared types for the AXI4-lite read-channel arbiter: FSM state encoding and RRESP codes.
package ysyx_23060208_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } rresp_e;

endpackage

// File: rtl/ysyx_23060208_rd_arbiter_if.sv
// NUM_PORTS-lane AXI4-lite read bundle (AR/R); lane i occupies slot [i*W +: W] of each wide field.
interface ysyx_23060208_rd_arbiter_if #(
  parameter int NUM_PORTS = 1,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [NUM_PORTS*ADDR_W-1:0] araddr;
  logic [NUM_PORTS-1:0]        arvalid;
  logic [NUM_PORTS-1:0]        arready;
  logic [NUM_PORTS*DATA_W-1:0] rdata;
  logic [NUM_PORTS*2-1:0]      rresp;
  logic [NUM_PORTS-1:0]        rvalid;
  logic [NUM_PORTS-1:0]        rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ysyx_23060208_rr_picker.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping modulo NUM_M.
module ysyx_23060208_rr_picker #(
  parameter  int NUM_M = 2,
  localparam int PTR_W = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NUM_M-1:0] pick,
  output logic             valid
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // NOTE: every variable driven here gets a default first, otherwise paths that skip an assignment infer latches.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_M; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_M);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/ysyx_23060208_rd_arbiter.sv
// Round-robin arbiter of NUM_M AXI4-lite read masters onto one slave read port, one transaction at a time.
// Optional slave-silence timeout with SLVERR completion: define RD_ARB_TIMEOUT_EN.
module ysyx_23060208_rd_arbiter
  import ysyx_23060208_rd_arbiter_pkg::*;
#(
  parameter int NUM_M          = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_23060208_rd_arbiter_if.slave  m,
  ysyx_23060208_rd_arbiter_if.master s,
  output logic [NUM_M-1:0]           grant
);

  localparam int PTR_W = $clog2(NUM_M);

  if (NUM_M < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("rd_arbiter: NUM_M must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_e          state;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    pick_idx;
  logic [PTR_W-1:0]    next_ptr;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   sel_addr;
  logic [NUM_M-1:0]    pick;
  logic                pick_valid;
  logic                arb_en;
  logic                live;
  logic                accept;
  logic                s_arvalid_c;
  logic                s_rready_c;
  logic                ar_hs;
  logic                r_hs;
  logic [NUM_M-1:0]        m_rvalid_c;
  logic [NUM_M*DATA_W-1:0] m_rdata_c;
  logic [NUM_M*2-1:0]      m_rresp_c;

  ysyx_23060208_rr_picker #(.NUM_M(NUM_M)) u_picker (
    .req   (m.arvalid),
    .ptr   (ptr),
    .pick  (pick),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    sel_addr = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (pick[i]) begin
        pick_idx = PTR_W'(i);
        sel_addr = m.araddr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign next_ptr = (grant_idx == PTR_W'(NUM_M - 1)) ? '0 : grant_idx + 1'b1;

  // arb_en keeps every handshake quiet in the first cycle after reset release.
  assign live        = rst & arb_en;
  assign accept      = live && (state == ST_IDLE) && pick_valid;
  assign s_arvalid_c = live && (state == ST_ADDR);
  assign s_rready_c  = live && (state == ST_DATA) && |(grant & m.rready);
  assign ar_hs       = s_arvalid_c && s.arready[0];
  assign r_hs        = s_rready_c && s.rvalid[0];

  assign m.arready = accept ? pick : '0;
  assign s.araddr  = addr_q;
  assign s.arvalid = s_arvalid_c;
  assign s.rready  = s_rready_c;

  always_comb begin
    m_rvalid_c = '0;
    m_rdata_c  = {NUM_M{s.rdata}};
    m_rresp_c  = {NUM_M{s.rresp}};
    if (live && (state == ST_DATA) && s.rvalid[0]) m_rvalid_c = grant;
`ifdef RD_ARB_TIMEOUT_EN
    if (live && (state == ST_ERR)) begin
      m_rvalid_c = grant;
      m_rdata_c  = '0;
      m_rresp_c  = {NUM_M{RESP_SLVERR}};
    end
`endif
  end

  assign m.rvalid = m_rvalid_c;
  assign m.rdata  = m_rdata_c;
  assign m.rresp  = m_rresp_c;

`ifdef RD_ARB_TIMEOUT_EN
  localparam int TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W    = (TO_BITS < 8) ? 8 : ((TO_BITS > 32) ? 32 : TO_BITS);
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  // to_hit marks the last permitted ADDR/DATA cycle, so ERR starts after exactly TIMEOUT_CYCLES cycles.
  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      grant     <= '0;
      grant_idx <= '0;
      addr_q    <= '0;
      arb_en    <= 1'b0;
`ifdef RD_ARB_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      arb_en <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            grant     <= pick;
            grant_idx <= pick_idx;
            addr_q    <= sel_addr;
            state     <= ST_ADDR;
`ifdef RD_ARB_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end
        end
        ST_ADDR: begin
          if (ar_hs) begin
            state <= ST_DATA;
          end
`ifdef RD_ARB_TIMEOUT_EN
          else if (to_hit) begin
            state <= ST_ERR;
          end
          to_cnt <= to_cnt + 1'b1;
`endif
        end
        ST_DATA: begin
          if (r_hs) begin
            ptr   <= next_ptr;
            grant <= '0;
            state <= ST_IDLE;
          end
`ifdef RD_ARB_TIMEOUT_EN
          else if (to_hit) begin
            state <= ST_ERR;
          end
          to_cnt <= to_cnt + 1'b1;
`endif
        end
`ifdef RD_ARB_TIMEOUT_EN
        ST_ERR: begin
          if (|(grant & m.rready)) begin
            ptr   <= next_ptr;
            grant <= '0;
            state <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_rd_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level round-robin model.
module tb_ysyx_23060208_rd_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk;
  logic          rst;
  logic [NM-1:0] grant;

  int            n_cmp;
  int            n_err;
  int            exp_ptr;
  int            w;
  logic [NM-1:0] pend;
  logic [NM-1:0] nw;
  logic [NM-1:0] oh;
  logic [AW-1:0] addr_tab [NM];

  ysyx_23060208_rd_arbiter_if #(.NUM_PORTS(NM), .ADDR_W(AW), .DATA_W(DW)) m_bus ();
  ysyx_23060208_rd_arbiter_if #(.NUM_PORTS(1),  .ADDR_W(AW), .DATA_W(DW)) s_bus ();

  ysyx_23060208_rd_arbiter #(
    .NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .m     (m_bus),
    .s     (s_bus),
    .grant (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration rule: first requester at or above the pointer, wrapping.
  function automatic int rr_pick(input logic [NM-1:0] req, input int p);
    for (int k = 0; k < NM; k++) begin
      if (req[(p + k) % NM]) return (p + k) % NM;
    end
    return -1;
  endfunction

  task automatic load_req();
    for (int i = 0; i < NM; i++) m_bus.araddr[i*AW +: AW] = addr_tab[i];
    m_bus.arvalid = pend;
  endtask

  task automatic do_txn(input int d_ar, input int d_r, input int stall,
                        input logic [DW-1:0] data, input logic [1:0] resp);
    load_req();
    w  = rr_pick(pend, exp_ptr);
    oh = NM'(1) << w;
    #1;
    check("arready_pick", m_bus.arready, oh);
    tick();
    pend[w] = 1'b0;
    m_bus.arvalid = pend;
    #1;
    check("grant_addr", grant, oh);
    check("s_arvalid", s_bus.arvalid, 1'b1);
    check("s_araddr", s_bus.araddr, addr_tab[w]);
    check("arready_in_addr", m_bus.arready, '0);
    repeat (d_ar) begin
      tick();
      check("s_arvalid_hold", s_bus.arvalid, 1'b1);
    end
    s_bus.arready = 1'b1;
    tick();
    s_bus.arready = 1'b0;
    check("s_arvalid_data", s_bus.arvalid, 1'b0);
    repeat (d_r) begin
      check("m_rvalid_wait", m_bus.rvalid, '0);
      tick();
    end
    s_bus.rvalid = 1'b1;
    s_bus.rdata  = data;
    s_bus.rresp  = resp;
    m_bus.rready = ~oh;
    repeat (stall) begin
      #1;
      check("s_rready_stall", s_bus.rready, 1'b0);
      check("m_rvalid_stall", m_bus.rvalid, oh);
      check("grant_stall", grant, oh);
      tick();
    end
    m_bus.rready = oh;
    #1;
    check("s_rready", s_bus.rready, 1'b1);
    check("m_rvalid", m_bus.rvalid, oh);
    check("m_rdata", m_bus.rdata, {NM{data}});
    check("m_rresp", m_bus.rresp, {NM{resp}});
    tick();
    s_bus.rvalid = 1'b0;
    m_bus.rready = '0;
    exp_ptr = (w + 1) % NM;
    #1;
    check("grant_done", grant, '0);
    check("m_rvalid_done", m_bus.rvalid, '0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    m_bus.araddr  = '0;
    m_bus.arvalid = '1;
    m_bus.rready  = '1;
    s_bus.arready = 1'b0;
    s_bus.rdata   = '0;
    s_bus.rresp   = '0;
    s_bus.rvalid  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, '0);
    check("rst_arready", m_bus.arready, '0);
    check("rst_s_arvalid", s_bus.arvalid, 1'b0);
    check("rst_s_rready", s_bus.rready, 1'b0);
    check("rst_m_rvalid", m_bus.rvalid, '0);
    rst = 1'b1;
    #1;
    check("arready_first_cycle", m_bus.arready, '0);
    m_bus.arvalid = '0;
    m_bus.rready  = '0;
    s_bus.rvalid  = 1'b0;
    tick();
    exp_ptr = 0;
    pend    = '0;
    for (int i = 0; i < NM; i++) addr_tab[i] = '0;

    // m1 alone, slave AR latency 2, DEADBEEF/OKAY.
    pend = 3'b010;
    addr_tab[1] = 32'h8000_0000;
    do_txn(2, 0, 0, 32'hDEAD_BEEF, 2'b00);

    // m0 and m1 held high: pointer sits at 2, so the order wraps to m0, then alternates.
    addr_tab[0] = 32'h0000_1000;
    addr_tab[1] = 32'h0000_2000;
    for (int t = 0; t < 4; t++) begin
      pend = pend | 3'b011;
      do_txn(t % 2, 1, 0, 32'h1111_0000 + t, 2'b00);
    end

    // m2 with the granted master back-pressuring R for 5 cycles, SLVERR passed through.
    pend = 3'b100;
    addr_tab[2] = 32'hA5A5_0004;
    do_txn(0, 1, 5, 32'hCAFE_F00D, 2'b10);

    // Stray slave rvalid while idle is not accepted.
    s_bus.rvalid = 1'b1;
    #1;
    check("stray_s_rready", s_bus.rready, 1'b0);
    check("stray_m_rvalid", m_bus.rvalid, '0);
    tick();
    s_bus.rvalid = 1'b0;
    check("stray_grant", grant, '0);

    // Reset asserted in DATA with rvalid/rready both high drops the transaction.
    pend = 3'b100;
    addr_tab[2] = 32'h1234_5678;
    load_req();
    #1;
    check("mid_arready", m_bus.arready, 3'b100);
    tick();
    pend = '0;
    m_bus.arvalid = '0;
    s_bus.arready = 1'b1;
    tick();
    s_bus.arready = 1'b0;
    s_bus.rvalid  = 1'b1;
    m_bus.rready  = 3'b100;
    rst = 1'b0;
    #1;
    check("mid_rst_s_rready", s_bus.rready, 1'b0);
    check("mid_rst_m_rvalid", m_bus.rvalid, '0);
    tick();
    check("mid_rst_grant", grant, '0);
    check("mid_rst_s_arvalid", s_bus.arvalid, 1'b0);
    rst = 1'b1;
    s_bus.rvalid = 1'b0;
    m_bus.rready = '0;
    tick();
    exp_ptr = 0;
    pend = 3'b110;
    addr_tab[1] = 32'h0BAD_0010;
    addr_tab[2] = 32'h0BAD_0020;
    do_txn(1, 0, 0, 32'h5555_AAAA, 2'b00);

    // Random traffic; masters keep their request and address until granted.
    for (int t = 0; t < 16; t++) begin
      nw = NM'($urandom_range(1, 7));
      for (int i = 0; i < NM; i++) begin
        if (nw[i] && !pend[i]) addr_tab[i] = $urandom;
      end
      pend = pend | nw;
      do_txn($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
             $urandom, 2'($urandom_range(0, 3)));
    end

    // Slave never accepts the address.
    pend = pend | 3'b001;
    addr_tab[0] = 32'hDEAD_0000;
    pend = 3'b001;
    load_req();
    w  = rr_pick(pend, exp_ptr);
    oh = NM'(1) << w;
    #1;
    check("stuck_arready", m_bus.arready, oh);
    tick();
    pend = '0;
    m_bus.arvalid = '0;
`ifdef RD_ARB_TIMEOUT_EN
    repeat (TO) tick();
    check("to_s_arvalid", s_bus.arvalid, 1'b0);
    check("to_m_rvalid", m_bus.rvalid, oh);
    check("to_m_rresp", m_bus.rresp, {NM{2'b10}});
    check("to_m_rdata", m_bus.rdata, '0);
    m_bus.rready = oh;
    tick();
    m_bus.rready = '0;
    check("to_grant_done", grant, '0);
`else
    repeat (100) tick();
    check("stuck_s_arvalid", s_bus.arvalid, 1'b1);
    check("stuck_grant", grant, oh);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
